// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - fetch_state_t : fetch controller state (2-bit encoding)
//   - DEF_RESET_PC  : default PC loaded on reset
//   - DEF_NOP_INSTR : default instruction shown while IF/ID is empty
//   - pc_plus4()    : 32-bit wrapping PC increment
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_SQUASH = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

   // Wraps modulo 2^32 by construction (32-bit result).
   function automatic logic [31:0] pc_plus4(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// ---------------------------------------------------------------------------
// ifid_reg
//   IF/ID pipeline register. Priority: flush > stall > load > drain.
//   Whenever the valid bit is cleared the instruction field is forced to
//   NOP_INSTR so downstream logic sees a bubble, not stale data.
// Ports:
//   clk, reset        : clock, async active-high reset
//   i_load            : capture i_pc / i_instr this cycle
//   i_stall           : hold contents
//   i_flush           : invalidate contents (beats stall and load)
//   i_pc, i_instr     : instruction to capture
//   o_valid, o_pc,
//   o_instr, o_pc4    : register contents (o_pc4 = captured pc + 4)
// ---------------------------------------------------------------------------
module ifid_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc4
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= NOP_INSTR;
         r_pc4   <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end else if (i_stall) begin
         r_valid <= r_valid;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_pc4   <= pc_plus4(i_pc);
      end else begin
         // nothing new arrived and decode consumed the old one: bubble
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage: owns the PC, runs the req/ack fetch handshake
//   to instruction memory and loads the IF/ID register.
// Ports:
//   clk, reset             : clock, async active-high reset
//   pc (out)               : current fetch PC, feeds the external PC adder
//   next_pc (in)           : PC adder result (pc+4 or jump target)
//   redirect (in)          : next_pc is a jump target this cycle
//   stall, flush (in)      : decode back-pressure / IF/ID invalidate
//   imem_req/addr (out)    : fetch request, address held until ack
//   imem_ack/rdata (in)    : one-cycle response pulse with instruction
//   ifid_valid/pc/instr/pc4: IF/ID register contents
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   input  logic        stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_pend_pc, w_pend_nxt;
   logic [31:0]  r_hold_instr, w_hold_nxt;
   logic         w_load;
   logic [31:0]  w_load_instr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_pend_pc    <= '0;
         r_hold_instr <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_pend_pc    <= w_pend_nxt;
         r_hold_instr <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_pend_nxt   = r_pend_pc;
      w_hold_nxt   = r_hold_instr;
      w_load       = 1'b0;
      w_load_instr = imem_rdata;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (redirect && !imem_ack) begin
               // request already on the bus: keep addr, finish it, then jump
               w_pend_nxt  = next_pc;
               w_state_nxt = ST_SQUASH;
            end else if (redirect) begin
               w_pc_nxt = next_pc;
            end else if (imem_ack && !stall) begin
               w_load   = 1'b1;
               w_pc_nxt = next_pc;
            end else if (imem_ack) begin
               w_hold_nxt  = imem_rdata;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               w_pc_nxt    = next_pc;
               w_state_nxt = ST_FETCH;
            end else if (!stall) begin
               w_load       = 1'b1;
               w_load_instr = r_hold_instr;
               w_pc_nxt     = next_pc;
               w_state_nxt  = ST_FETCH;
            end
         end
         ST_SQUASH: begin
            if (redirect) w_pend_nxt = next_pc;
            if (imem_ack) begin
               w_pc_nxt    = redirect ? next_pc : r_pend_pc;
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   assign pc        = r_pc;
   assign imem_addr = r_pc;
   assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_SQUASH);

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_stall (stall),
      .i_flush (flush),
      .i_pc    (r_pc),
      .i_instr (w_load_instr),
      .o_valid (ifid_valid),
      .o_pc    (ifid_pc),
      .o_instr (ifid_instr),
      .o_pc4   (ifid_pc4)
   );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the architectural PC register, issues req/ack fetches to instruction memory, and loads the IF/ID pipeline register.
- Drives `pc` into the PC adder and consumes its `pc_4` result (`next_pc`, which is already `pc+4` or the jump/forward target).
- Handles decode stalls, pipeline flushes, and redirects that arrive while a memory request is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000: value driven on `ifid_instr` while `ifid_valid` is 0.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  out  32  current fetch PC; feeds the PC adder.
- next_pc  in  32  PC adder output (`pc_4`).
- redirect  in  1  high while the PC adder's jump select is non-zero; `next_pc` is then a target.
- stall  in  1  decode cannot accept; hold IF/ID.
- flush  in  1  invalidate IF/ID contents.
- imem_req  out  1  fetch request; `imem_addr` is held stable while high and not acked.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  one-cycle pulse; `imem_rdata` is valid in that cycle.
- imem_rdata  in  32  fetched instruction.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  `ifid_pc + 4`, for link and branch arithmetic.

Behaviour:
- Reset (asynchronous, any state, including mid-request):
  - pc = RESET_PC; state = BOOT; pend_pc = 0; hold_instr = 0.
  - ifid_valid = 0, ifid_pc = 0, ifid_instr = NOP_INSTR, ifid_pc4 = 0.
  - imem_req = 0. An outstanding ack arriving after reset is ignored.
- Output encoding: imem_req = (state==FETCH or SQUASH). imem_addr = pc in all states.
- BOOT: req=0; go to FETCH next cycle. First request appears in the 2nd cycle after reset release.
- FETCH, per cycle, in priority order:
  - redirect & !ack: pend_pc <= next_pc; go to SQUASH. pc is held so the address stays stable.
  - redirect & ack: discard rdata; pc <= next_pc; stay in FETCH.
  - ack & !stall: IF/ID <= {1, pc, rdata, pc+4}; pc <= next_pc. Back-to-back acks give one instruction per cycle.
  - ack & stall: hold_instr <= rdata; go to HOLD. pc is held.
  - else: hold all state.
- HOLD: req=0.
  - redirect: drop hold_instr; pc <= next_pc; go to FETCH.
  - else !stall: IF/ID <= {1, pc, hold_instr, pc+4}; pc <= next_pc; go to FETCH.
- SQUASH: req=1 at the old pc.
  - redirect: pend_pc <= next_pc (latest target wins).
  - ack: discard rdata; pc <= (redirect ? next_pc : pend_pc); go to FETCH.
- IF/ID register, in priority order:
  - flush: ifid_valid <= 0 and ifid_instr <= NOP_INSTR; flush overrides stall and overrides any load in the same cycle.
  - stall: hold.
  - no load this cycle and not stalled: ifid_valid <= 0.
- Flush alone does not change pc or state; redirect handling is independent of flush.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment checks.

Decomposition:
- fetch_pkg holds:
  - state enum {BOOT, FETCH, HOLD, SQUASH}, 2-bit encoding.
  - default RESET_PC and NOP_INSTR constants.
- Sub-module ifid_reg: the IF/ID pipeline register with load/stall/flush priority and async reset. fetch_unit instantiates it once.
- The PC adder stays external.

Test Plan:
- Reset release, ack held high every cycle:
  - imem_req rises in cycle 2.
  - imem_addr = 0, 4, 8.
  - ifid_pc/ifid_pc4 = 0/4, 4/8, 8/12, with ifid_valid = 1 from the cycle after the first ack.
- Ack delayed 3 cycles at pc=0x10: imem_addr stays 0x10 for 3 cycles; IF/ID loads 0x10 only after the ack; no duplicate load.
- Ack at pc=0x20 with stall=1 for 2 cycles:
  - state HOLD, imem_req=0, IF/ID unchanged.
  - On stall drop, ifid_pc=0x20 with the captured instruction, then the fetch of 0x24 starts.
- Redirect (next_pc=0x100) while the request to 0x30 is pending:
  - Addr stays 0x30 until ack; rdata discarded; ifid_valid=0.
  - Next request is at 0x100.
- flush and stall together with valid IF/ID: ifid_valid=0, ifid_instr=NOP_INSTR next cycle; pc unchanged.
- Edge cases:
  - reset asserted mid-SQUASH: pc=RESET_PC immediately, a late ack produces no load.
  - Wrap case: pc=32'hFFFF_FFFC gives ifid_pc4=0.
